// File: rtl/txt_pkg.sv
// Shared types and address constants for the text/main RAM arbiter.
package txt_pkg;

  // Owner of an in-flight RAM access.
  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  // Text page window, shared with the video fetcher and the bench.
  localparam logic [15:0] TXT_BASE = 16'h0400;
  localparam logic [15:0] TXT_END  = 16'h07FF;

  // Width of the CPU starvation counter.
  localparam int unsigned STARVE_W = 4;

endpackage : txt_pkg

// File: rtl/txt_rdpipe.sv
// Read-return pipeline: tracks owner and valid of each issued access for two
// cycles, then routes the RAM read data to the requester that issued it.
// A write enters as invalid, so it never produces a qv pulse.
module txt_rdpipe
  import txt_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_vld_i,
  input  owner_t        issue_own_i,
  input  logic [DW-1:0] mem_q_i,
  output logic [DW-1:0] cpu_q_o,
  output logic          cpu_qv_o,
  output logic [DW-1:0] vid_q_o,
  output logic          vid_qv_o
);

  logic [1:0]    vld_q;
  owner_t        own1_q;
  owner_t        own2_q;

  logic [DW-1:0] cpu_q_q;
  logic [DW-1:0] cpu_q_d;
  logic          cpu_qv_q;
  logic          cpu_qv_d;
  logic [DW-1:0] vid_q_q;
  logic [DW-1:0] vid_q_d;
  logic          vid_qv_q;
  logic          vid_qv_d;

  // Shift owner/valid along with the RAM access: stage 1 is the cycle mem_adr
  // is presented, stage 2 the cycle mem_q carries the data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      own1_q <= OWN_VID;
      own2_q <= OWN_VID;
    end else begin
      vld_q  <= {vld_q[0], issue_vld_i};
      own1_q <= issue_own_i;
      own2_q <= own1_q;
    end
  end

  // Route stage-2 data to its owner; the other requester's data holds.
  always_comb begin
    cpu_q_d  = cpu_q_q;
    vid_q_d  = vid_q_q;
    cpu_qv_d = 1'b0;
    vid_qv_d = 1'b0;
    if (vld_q[1]) begin
      if (own2_q == OWN_CPU) begin
        cpu_q_d  = mem_q_i;
        cpu_qv_d = 1'b1;
      end else begin
        vid_q_d  = mem_q_i;
        vid_qv_d = 1'b1;
      end
    end
  end

  // Register the returned data and the one-cycle valid pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_q_q  <= '0;
      cpu_qv_q <= 1'b0;
      vid_q_q  <= '0;
      vid_qv_q <= 1'b0;
    end else begin
      cpu_q_q  <= cpu_q_d;
      cpu_qv_q <= cpu_qv_d;
      vid_q_q  <= vid_q_d;
      vid_qv_q <= vid_qv_d;
    end
  end

  assign cpu_q_o  = cpu_q_q;
  assign cpu_qv_o = cpu_qv_q;
  assign vid_q_o  = vid_q_q;
  assign vid_qv_o = vid_qv_q;

endmodule : txt_rdpipe

// File: rtl/txt_arbiter.sv
// Arbiter sharing the single-port text/main RAM between the CPU bus and the
// video text fetcher. Video wins contention so raster timing holds; a
// starvation counter forces a CPU win after STARVE consecutive denied cycles.
module txt_arbiter
  import txt_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [DW-1:0] cpu_d_i,
  output logic          cpu_gnt_o,
  output logic [DW-1:0] cpu_q_o,
  output logic          cpu_qv_o,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_adr_i,
  output logic          vid_gnt_o,
  output logic [DW-1:0] vid_q_o,
  output logic          vid_qv_o,
  output logic [AW-1:0] mem_adr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_d_o,
  input  logic [DW-1:0] mem_q_i
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;
  logic                cpu_force;
  logic                cpu_gnt;
  logic                vid_gnt;

  logic [AW-1:0]       mem_adr_q;
  logic [AW-1:0]       mem_adr_d;
  logic                mem_we_q;
  logic                mem_we_d;
  logic [DW-1:0]       mem_d_q;
  logic [DW-1:0]       mem_d_d;
  logic                issue_vld;
  owner_t              issue_own;

  // Grant: a lone requester always wins; on contention video wins unless the
  // CPU has been denied STARVE times. Reset drops both grants at once.
  always_comb begin
    cpu_force = (starve_cnt_q == STARVE_MAX);
    cpu_gnt   = reset && cpu_req_i && (!vid_req_i || cpu_force);
    vid_gnt   = reset && vid_req_i && !(cpu_req_i && cpu_force);
  end

  assign cpu_gnt_o = cpu_gnt;
  assign vid_gnt_o = vid_gnt;

  // Count consecutive denied CPU cycles; any CPU transfer or dropped request
  // restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req_i || cpu_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Issue stage: load the winner's access. Idle cycles keep address and data
  // stable and only deassert the write enable.
  always_comb begin
    mem_adr_d = mem_adr_q;
    mem_d_d   = mem_d_q;
    mem_we_d  = 1'b0;
    issue_vld = 1'b0;
    issue_own = OWN_VID;
    if (cpu_gnt) begin
      mem_adr_d = cpu_adr_i;
      mem_d_d   = cpu_d_i;
      mem_we_d  = cpu_we_i;
      issue_vld = !cpu_we_i;
      issue_own = OWN_CPU;
    end else if (vid_gnt) begin
      mem_adr_d = vid_adr_i;
      issue_vld = 1'b1;
      issue_own = OWN_VID;
    end
  end

  // RAM-side registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_adr_q <= '0;
      mem_we_q  <= 1'b0;
      mem_d_q   <= '0;
    end else begin
      mem_adr_q <= mem_adr_d;
      mem_we_q  <= mem_we_d;
      mem_d_q   <= mem_d_d;
    end
  end

  assign mem_adr_o = mem_adr_q;
  assign mem_we_o  = mem_we_q;
  assign mem_d_o   = mem_d_q;

  txt_rdpipe #(
    .DW(DW)
  ) u_rdpipe (
    .clk        (clk),
    .reset      (reset),
    .issue_vld_i(issue_vld),
    .issue_own_i(issue_own),
    .mem_q_i    (mem_q_i),
    .cpu_q_o    (cpu_q_o),
    .cpu_qv_o   (cpu_qv_o),
    .vid_q_o    (vid_q_o),
    .vid_qv_o   (vid_qv_o)
  );

endmodule : txt_arbiter

// File: tb/tb_txt_arbiter.sv
// Directed bench for txt_arbiter with a scoreboard on the read-return path.
module tb_txt_arbiter;
  import txt_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_d;
  logic        cpu_gnt;
  logic [7:0]  cpu_q;
  logic        cpu_qv;
  logic        vid_req;
  logic [15:0] vid_adr;
  logic        vid_gnt;
  logic [7:0]  vid_q;
  logic        vid_qv;
  logic [15:0] mem_adr;
  logic        mem_we;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       own;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];

  txt_arbiter #(.AW(16), .DW(8), .STARVE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req_i(cpu_req),
    .cpu_we_i (cpu_we),
    .cpu_adr_i(cpu_adr),
    .cpu_d_i  (cpu_d),
    .cpu_gnt_o(cpu_gnt),
    .cpu_q_o  (cpu_q),
    .cpu_qv_o (cpu_qv),
    .vid_req_i(vid_req),
    .vid_adr_i(vid_adr),
    .vid_gnt_o(vid_gnt),
    .vid_q_o  (vid_q),
    .vid_qv_o (vid_qv),
    .mem_adr_o(mem_adr),
    .mem_we_o (mem_we),
    .mem_d_o  (mem_d),
    .mem_q_i  (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preloaded contents come from a table, written bytes override.
  logic [7:0] wmem [0:65535];
  bit         wflag[0:65535];

  function automatic logic [7:0] preload(input logic [15:0] a);
    case (a)
      16'h0428: return 8'hC1;
      16'h0440: return 8'h33;
      16'h07D0: return 8'h5A;
      16'h0480: return 8'h11;
      16'h0500: return 8'h22;
      default:  return 8'hEE;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_q <= wflag[mem_adr] ? wmem[mem_adr] : preload(mem_adr);
    if (mem_we) begin
      wmem[mem_adr]  <= mem_d;
      wflag[mem_adr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic own, input logic [7:0] d);
    exp_t e;
    e.own = own;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (5) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every qv pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (reset) begin
      if (cpu_qv && vid_qv) begin
        checks++;
        errors++;
        $display("FAIL both_qv: cpu_qv=1 vid_qv=1 required at most one at %0t", $time);
      end else if (cpu_qv || vid_qv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_qv: cpu_qv=%0b vid_qv=%0b with no read outstanding at %0t",
                   cpu_qv, vid_qv, $time);
        end else begin
          exp_t e;
          logic [7:0] got;
          e   = exp_q.pop_front();
          got = cpu_qv ? cpu_q : vid_q;
          if (cpu_qv !== e.own || got !== e.d) begin
            errors++;
            $display("FAIL read_return: owner_cpu=%0b data=%0h expected owner_cpu=%0b data=%0h at %0t",
                     cpu_qv, got, e.own, e.d, $time);
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b0;
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    cpu_adr = '0;
    cpu_d   = '0;
    vid_req = 1'b1;
    vid_adr = '0;
    repeat (2) step();
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_vid_gnt", 32'(vid_gnt), 32'd0);
    cpu_req = 1'b0;
    vid_req = 1'b0;
    #2 reset = 1'b1;
    step();
    chk("idle_outs", {cpu_q, vid_q, 6'd0, cpu_qv, vid_qv, 8'd0},  32'd0);
    chk("idle_mem", {mem_adr, mem_d, 7'd0, mem_we}, 32'd0);
    chk("idle_gnt", {30'd0, cpu_gnt, vid_gnt}, 32'd0);

    // CPU write 0x41 to the text base
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = TXT_BASE; cpu_d = 8'h41;
    #1 chk("wr_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_adr", 32'(mem_adr), 32'h0400);
    chk("wr_mem_d", 32'(mem_d), 32'h41);
    step();
    chk("wr_we_drop", 32'(mem_we), 32'd0);
    chk("wr_stored", 32'(wmem[16'h0400]), 32'h41);
    // read it back through the CPU port
    cpu_req = 1'b1; cpu_adr = TXT_BASE;
    push(1'b1, 8'h41);
    step();
    cpu_req = 1'b0;
    drain();

    // Video read with exact latency check
    vid_req = 1'b1; vid_adr = 16'h0428;
    #1 chk("vrd_vid_gnt", 32'(vid_gnt), 32'd1);
    chk("vrd_cpu_gnt", 32'(cpu_gnt), 32'd0);
    push(1'b0, 8'hC1);
    step();
    vid_req = 1'b0;
    step();
    chk("vrd_qv_early", 32'(vid_qv), 32'd0);
    step();
    chk("vrd_qv", 32'(vid_qv), 32'd1);
    chk("vrd_q", 32'(vid_q), 32'hC1);
    chk("vrd_cpu_qv", 32'(cpu_qv), 32'd0);
    step();
    chk("vrd_qv_pulse", 32'(vid_qv), 32'd0);
    drain();

    // Starvation: video held, CPU denied 4 cycles then forced through
    vid_req = 1'b1; vid_adr = 16'h0440;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h07D0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("stv_deny", 32'(cpu_gnt), 32'd0);
      chk("stv_vid", 32'(vid_gnt), 32'd1);
      push(1'b0, 8'h33);
      step();
    end
    #1 chk("stv_win", 32'(cpu_gnt), 32'd1);
    chk("stv_vid_off", 32'(vid_gnt), 32'd0);
    push(1'b1, 8'h5A);
    step();
    cpu_req = 1'b0;
    #1 chk("stv_vid_resume", 32'(vid_gnt), 32'd1);
    push(1'b0, 8'h33);
    step();
    vid_req = 1'b0;
    drain();

    // Alternating back-to-back CPU and video reads
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'b1; cpu_adr = 16'h0480; vid_req = 1'b0;
      push(1'b1, 8'h11);
      step();
      cpu_req = 1'b0; vid_req = 1'b1; vid_adr = 16'h0500;
      push(1'b0, 8'h22);
      step();
    end
    vid_req = 1'b0;
    drain();

    // CPU drops after 3 denied cycles: count restarts
    vid_req = 1'b1; vid_adr = 16'h0440;
    cpu_req = 1'b1; cpu_adr = 16'h07D0;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 8'h33);
      step();
    end
    cpu_req = 1'b0;
    push(1'b0, 8'h33);
    step();
    cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drop_deny", 32'(cpu_gnt), 32'd0);
      push(1'b0, 8'h33);
      step();
    end
    #1 chk("drop_win", 32'(cpu_gnt), 32'd1);
    push(1'b1, 8'h5A);
    step();
    cpu_req = 1'b0; vid_req = 1'b0;
    drain();

    // Reset one cycle after a video read transfer discards it
    vid_req = 1'b1; vid_adr = 16'h0500;
    step();
    step();
    reset = 1'b0;
    #1 chk("rst_gnt_drop", 32'(vid_gnt), 32'd0);
    step();
    step();
    vid_req = 1'b0;
    #2 reset = 1'b1;
    repeat (5) step();
    chk("rst_outs", {cpu_q, vid_q, 6'd0, cpu_qv, vid_qv, 8'd0}, 32'd0);
    chk("rst_mem", {mem_adr, mem_d, 7'd0, mem_we}, 32'd0);
    chk("rst_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_txt_arbiter
